// File: rtl/preg_file_sb.sv
// Physical register file with a per-register ready scoreboard for a renaming core.
// Reads see this edge's writes, allocs and flush; preg 0 is hardwired to zero and ready.
module preg_file_sb #(
    parameter int NUM_PREGS = 64,
    parameter int DATA_W    = 32,
    parameter int NUM_RD    = 8,
    parameter int NUM_WR    = 4,
    parameter int NUM_ALLOC = 2,
    localparam int PW       = $clog2(NUM_PREGS),
    localparam int BW       = $clog2(NUM_PREGS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RD-1:0]                rd_en,
    input  logic [NUM_RD-1:0][PW-1:0]        rd_idx,
    output logic [NUM_RD-1:0][DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]                rd_ready,
    input  logic [NUM_WR-1:0]                wr_en,
    input  logic [NUM_WR-1:0][PW-1:0]        wr_idx,
    input  logic [NUM_WR-1:0][DATA_W-1:0]    wr_data,
    input  logic [NUM_ALLOC-1:0]             alloc_en,
    input  logic [NUM_ALLOC-1:0][PW-1:0]     alloc_idx,
    input  logic                             flush,
    output logic                             wr_conflict,
    output logic [BW-1:0]                    busy_count
);

    // All ports are accepted every cycle; there is no handshake or backpressure.
    logic [DATA_W-1:0]    data_q   [NUM_PREGS];
    logic [DATA_W-1:0]    nxt_data [NUM_PREGS];
    logic [NUM_PREGS-1:0] ready_q;
    logic [NUM_PREGS-1:0] nxt_ready;
    logic                 conflict;
    logic [BW-1:0]        nxt_busy;

    always_comb begin
        nxt_data  = data_q;
        nxt_ready = ready_q;
        conflict  = 1'b0;
        nxt_busy  = '0;
        // Ascending port order lets the highest-numbered writer win.
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_idx[w] != '0) begin
                nxt_data[wr_idx[w]]  = wr_data[w];
                nxt_ready[wr_idx[w]] = 1'b1;
            end
        end
        // Allocs are applied after writes so a same-cycle alloc leaves the register busy.
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (!flush && alloc_en[a] && alloc_idx[a] != '0)
                nxt_ready[alloc_idx[a]] = 1'b0;
        end
        if (flush)
            nxt_ready = '1;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_en[i] && wr_en[j] && wr_idx[i] == wr_idx[j] && wr_idx[i] != '0)
                    conflict = 1'b1;
            end
        end
        for (int i = 0; i < NUM_PREGS; i++) begin
            if (!nxt_ready[i])
                nxt_busy = nxt_busy + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREGS; i++)
                data_q[i] <= '0;
            ready_q     <= '1;
            rd_data     <= '0;
            rd_ready    <= '0;
            wr_conflict <= 1'b0;
            busy_count  <= '0;
        end else begin
            data_q      <= nxt_data;
            ready_q     <= nxt_ready;
            wr_conflict <= conflict;
            busy_count  <= nxt_busy;
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_en[p]) begin
                    rd_data[p]  <= nxt_data[rd_idx[p]];
                    rd_ready[p] <= nxt_ready[rd_idx[p]];
                end
            end
        end
    end

endmodule

// File: tb/tb_preg_file_sb.sv
// Bench for preg_file_sb: directed scenarios plus a randomized run against a behavioural model.
// Expected read results ({ready, data}) are queued at drive time and popped after the edge.
module tb_preg_file_sb;
    localparam int NUM_PREGS = 64;
    localparam int DATA_W    = 32;
    localparam int NUM_RD    = 8;
    localparam int NUM_WR    = 4;
    localparam int NUM_ALLOC = 2;
    localparam int PW        = $clog2(NUM_PREGS);
    localparam int BW        = $clog2(NUM_PREGS + 1);

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_RD-1:0]             rd_en;
    logic [NUM_RD-1:0][PW-1:0]     rd_idx;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_ready;
    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][PW-1:0]     wr_idx;
    logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
    logic [NUM_ALLOC-1:0]          alloc_en;
    logic [NUM_ALLOC-1:0][PW-1:0]  alloc_idx;
    logic                          flush;
    logic                          wr_conflict;
    logic [BW-1:0]                 busy_count;

    logic [DATA_W:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    preg_file_sb #(
        .NUM_PREGS(NUM_PREGS), .DATA_W(DATA_W), .NUM_RD(NUM_RD),
        .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_idx(alloc_idx), .flush(flush),
        .wr_conflict(wr_conflict), .busy_count(busy_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; flush = 1'b0;
        rd_en = '0; rd_idx = '0;
        wr_en = '0; wr_idx = '0; wr_data = '0;
        alloc_en = '0; alloc_idx = '0;
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read0(input int idx, input logic [DATA_W:0] exp);
        rd_en[0] = 1'b1;
        rd_idx[0] = PW'(idx);
        exp_q.push_back(exp);
    endtask

    task automatic test_reset();
        logic [DATA_W:0] exp;
        idle();
        rst = 1'b1;
        wr_en[0] = 1'b1; wr_idx[0] = PW'(5); wr_data[0] = 32'h1234;
        alloc_en[0] = 1'b1; alloc_idx[0] = PW'(6);
        rd_en = '1;
        step();
        step();
        n_vec++;
        if (rd_data !== '0 || rd_ready !== '0) begin
            n_err++;
            $display("FAIL reset_rd: rd_data=%h rd_ready=%b required 0/0", rd_data, rd_ready);
        end
        n_vec++;
        if (busy_count !== '0 || wr_conflict !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: busy=%0d conflict=%b required 0/0", busy_count, wr_conflict);
        end
        idle();
        read0(5, {1'b1, 32'h0});
        step();
        exp = exp_q.pop_front();
        n_vec++;
        if ({rd_ready[0], rd_data[0]} !== exp) begin
            n_err++;
            $display("FAIL reset_read5: got %h required %h", {rd_ready[0], rd_data[0]}, exp);
        end
        n_vec++;
        if (busy_count !== BW'(0)) begin
            n_err++;
            $display("FAIL reset_busy: got %0d required 0", busy_count);
        end
    endtask

    task automatic test_alloc_write();
        logic [DATA_W:0] exp;
        idle();
        alloc_en[0] = 1'b1; alloc_idx[0] = PW'(7);
        step();
        idle();
        read0(7, {1'b0, 32'h0});
        step();
        exp = exp_q.pop_front();
        n_vec++;
        if ({rd_ready[0], rd_data[0]} !== exp) begin
            n_err++;
            $display("FAIL alloc_read7: got %h required %h", {rd_ready[0], rd_data[0]}, exp);
        end
        n_vec++;
        if (busy_count !== BW'(1)) begin
            n_err++;
            $display("FAIL alloc_busy: got %0d required 1", busy_count);
        end
        idle();
        wr_en[1] = 1'b1; wr_idx[1] = PW'(7); wr_data[1] = 32'hDEADBEEF;
        read0(7, {1'b1, 32'hDEADBEEF});
        step();
        exp = exp_q.pop_front();
        n_vec++;
        if ({rd_ready[0], rd_data[0]} !== exp) begin
            n_err++;
            $display("FAIL write_bypass7: got %h required %h", {rd_ready[0], rd_data[0]}, exp);
        end
        n_vec++;
        if (busy_count !== BW'(0)) begin
            n_err++;
            $display("FAIL write_busy: got %0d required 0", busy_count);
        end
    endtask

    task automatic test_conflict();
        logic [DATA_W:0] exp;
        idle();
        wr_en[0] = 1'b1; wr_idx[0] = PW'(9); wr_data[0] = 32'h11;
        wr_en[2] = 1'b1; wr_idx[2] = PW'(9); wr_data[2] = 32'h22;
        step();
        n_vec++;
        if (wr_conflict !== 1'b1) begin
            n_err++;
            $display("FAIL conflict_set: got %b required 1", wr_conflict);
        end
        idle();
        read0(9, {1'b1, 32'h22});
        step();
        n_vec++;
        if (wr_conflict !== 1'b0) begin
            n_err++;
            $display("FAIL conflict_clear: got %b required 0", wr_conflict);
        end
        exp = exp_q.pop_front();
        n_vec++;
        if ({rd_ready[0], rd_data[0]} !== exp) begin
            n_err++;
            $display("FAIL conflict_data: got %h required %h", {rd_ready[0], rd_data[0]}, exp);
        end
    endtask

    task automatic test_flush();
        logic [DATA_W:0] exp;
        idle();
        alloc_en = 2'b11; alloc_idx[0] = PW'(3); alloc_idx[1] = PW'(4);
        step();
        idle();
        alloc_en[0] = 1'b1; alloc_idx[0] = PW'(5);
        step();
        n_vec++;
        if (busy_count !== BW'(3)) begin
            n_err++;
            $display("FAIL flush_pre_busy: got %0d required 3", busy_count);
        end
        idle();
        flush = 1'b1;
        alloc_en[0] = 1'b1; alloc_idx[0] = PW'(6);
        read0(6, {1'b1, 32'h0});
        step();
        exp = exp_q.pop_front();
        n_vec++;
        if ({rd_ready[0], rd_data[0]} !== exp) begin
            n_err++;
            $display("FAIL flush_read6: got %h required %h", {rd_ready[0], rd_data[0]}, exp);
        end
        n_vec++;
        if (busy_count !== BW'(0)) begin
            n_err++;
            $display("FAIL flush_busy: got %0d required 0", busy_count);
        end
        idle();
        read0(3, {1'b1, 32'h0});
        step();
        exp = exp_q.pop_front();
        n_vec++;
        if ({rd_ready[0], rd_data[0]} !== exp) begin
            n_err++;
            $display("FAIL flush_read3: got %h required %h", {rd_ready[0], rd_data[0]}, exp);
        end
    endtask

    task automatic test_zero_reg();
        logic [DATA_W:0] exp;
        idle();
        alloc_en[1] = 1'b1; alloc_idx[1] = PW'(12);
        step();
        idle();
        wr_en[3] = 1'b1; wr_idx[3] = PW'(0); wr_data[3] = 32'hFFFF;
        alloc_en[0] = 1'b1; alloc_idx[0] = PW'(0);
        read0(0, {1'b1, 32'h0});
        step();
        exp = exp_q.pop_front();
        n_vec++;
        if ({rd_ready[0], rd_data[0]} !== exp) begin
            n_err++;
            $display("FAIL zero_read: got %h required %h", {rd_ready[0], rd_data[0]}, exp);
        end
        n_vec++;
        if (busy_count !== BW'(1)) begin
            n_err++;
            $display("FAIL zero_busy: got %0d required 1", busy_count);
        end
    endtask

    task automatic test_alloc_wins();
        logic [DATA_W:0] exp;
        idle();
        flush = 1'b1;
        step();
        idle();
        alloc_en[1] = 1'b1; alloc_idx[1] = PW'(10);
        wr_en[2] = 1'b1; wr_idx[2] = PW'(10); wr_data[2] = 32'h5A;
        step();
        idle();
        read0(10, {1'b0, 32'h5A});
        step();
        exp = exp_q.pop_front();
        n_vec++;
        if ({rd_ready[0], rd_data[0]} !== exp) begin
            n_err++;
            $display("FAIL alloc_wins_read: got %h required %h", {rd_ready[0], rd_data[0]}, exp);
        end
        n_vec++;
        if (busy_count !== BW'(1)) begin
            n_err++;
            $display("FAIL alloc_wins_busy: got %0d required 1", busy_count);
        end
    endtask

    task automatic test_mid_reset();
        logic [DATA_W:0] exp;
        idle();
        rst = 1'b1;
        alloc_en[0] = 1'b1; alloc_idx[0] = PW'(20);
        wr_en[0] = 1'b1; wr_idx[0] = PW'(21); wr_data[0] = 32'hABCD;
        step();
        n_vec++;
        if (busy_count !== BW'(0) || rd_ready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_state: busy=%0d rd_ready=%b required 0/0", busy_count, rd_ready[0]);
        end
        idle();
        read0(21, {1'b1, 32'h0});
        step();
        exp = exp_q.pop_front();
        n_vec++;
        if ({rd_ready[0], rd_data[0]} !== exp) begin
            n_err++;
            $display("FAIL midrst_read21: got %h required %h", {rd_ready[0], rd_data[0]}, exp);
        end
    endtask

    // Randomized traffic over a small index range so collisions are frequent.
    task automatic test_random();
        logic [DATA_W-1:0] m_data [NUM_PREGS];
        logic              m_ready[NUM_PREGS];
        logic [DATA_W:0]   last   [NUM_RD];
        logic [DATA_W:0]   exp;
        logic              exp_conf;
        int                exp_busy;
        int                ix;
        idle();
        rst = 1'b1;
        step();
        idle();
        for (int i = 0; i < NUM_PREGS; i++) begin
            m_data[i] = '0;
            m_ready[i] = 1'b1;
        end
        for (int p = 0; p < NUM_RD; p++) last[p] = '0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            flush = ($urandom_range(0, 15) == 0);
            for (int w = 0; w < NUM_WR; w++) begin
                wr_en[w] = $urandom_range(0, 1) == 1;
                wr_idx[w] = PW'($urandom_range(0, 15));
                wr_data[w] = DATA_W'($urandom());
            end
            for (int a = 0; a < NUM_ALLOC; a++) begin
                alloc_en[a] = $urandom_range(0, 1) == 1;
                alloc_idx[a] = PW'($urandom_range(0, 15));
            end
            for (int p = 0; p < NUM_RD; p++) begin
                rd_en[p] = $urandom_range(0, 3) != 0;
                rd_idx[p] = PW'($urandom_range(0, 15));
            end
            exp_conf = 1'b0;
            for (int i = 0; i < NUM_WR; i++)
                for (int j = i + 1; j < NUM_WR; j++)
                    if (wr_en[i] && wr_en[j] && wr_idx[i] == wr_idx[j] && wr_idx[i] != 0)
                        exp_conf = 1'b1;
            for (int w = 0; w < NUM_WR; w++) begin
                ix = int'(wr_idx[w]);
                if (wr_en[w] && ix != 0) begin
                    m_data[ix] = wr_data[w];
                    m_ready[ix] = 1'b1;
                end
            end
            for (int a = 0; a < NUM_ALLOC; a++) begin
                ix = int'(alloc_idx[a]);
                if (alloc_en[a] && ix != 0 && !flush) m_ready[ix] = 1'b0;
            end
            exp_busy = 0;
            for (int i = 0; i < NUM_PREGS; i++) begin
                if (flush) m_ready[i] = 1'b1;
                if (!m_ready[i]) exp_busy++;
            end
            for (int p = 0; p < NUM_RD; p++) begin
                ix = int'(rd_idx[p]);
                if (rd_en[p]) last[p] = {m_ready[ix], m_data[ix]};
                exp_q.push_back(last[p]);
            end
            step();
            for (int p = 0; p < NUM_RD; p++) begin
                exp = exp_q.pop_front();
                n_vec++;
                if ({rd_ready[p], rd_data[p]} !== exp) begin
                    n_err++;
                    $display("FAIL rand_read cyc=%0d port=%0d: got %h required %h",
                             cyc, p, {rd_ready[p], rd_data[p]}, exp);
                end
            end
            n_vec++;
            if (busy_count !== BW'(exp_busy)) begin
                n_err++;
                $display("FAIL rand_busy cyc=%0d: got %0d required %0d", cyc, busy_count, exp_busy);
            end
            n_vec++;
            if (wr_conflict !== exp_conf) begin
                n_err++;
                $display("FAIL rand_conflict cyc=%0d: got %b required %b", cyc, wr_conflict, exp_conf);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_alloc_write();
        test_conflict();
        test_flush();
        test_zero_reg();
        test_alloc_wins();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/preg_file_sb.md
PREG_FILE_SB -- requirements
Module: preg_file_sb

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 64, number of physical registers (power of 2, >=4).
REQ-002 SHALL have parameter DATA_W, default 32, register width.
REQ-003 SHALL have parameter NUM_RD, default 8, read port count.
REQ-004 SHALL have parameter NUM_WR, default 4, write port count.
REQ-005 SHALL have parameter NUM_ALLOC, default 2, allocate port count; PW = $clog2(NUM_PREGS).
REQ-006 SHALL have port: clk  in  1  sole clock, all state on posedge.
REQ-007 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port: rd_en  in  [NUM_RD]  per-port read request.
REQ-009 SHALL have port: rd_idx  in  [NUM_RD][PW]  read register index.
REQ-010 SHALL have port: rd_data  out  [NUM_RD][DATA_W]  registered read data.
REQ-011 SHALL have port: rd_ready  out  [NUM_RD]  registered ready bit of the read register.
REQ-012 SHALL have port: wr_en  in  [NUM_WR]  writeback valid.
REQ-013 SHALL have port: wr_idx  in  [NUM_WR][PW]  writeback destination.
REQ-014 SHALL have port: wr_data  in  [NUM_WR][DATA_W]  writeback value.
REQ-015 SHALL have port: alloc_en  in  [NUM_ALLOC]  rename allocation valid.
REQ-016 SHALL have port: alloc_idx  in  [NUM_ALLOC][PW]  newly allocated destination.
REQ-017 SHALL have port: flush  in  1  return scoreboard to non-speculative state.
REQ-018 SHALL have port: wr_conflict  out  1  registered pulse, same-cycle duplicate write index.
REQ-019 SHALL have port: busy_count  out  $clog2(NUM_PREGS+1)  registered count of not-ready registers.

Function
REQ-020 SHALL hardwire preg 0: reads return 0 and ready=1; writes and allocs to index 0 are ignored and never counted.
REQ-021 SHALL update state each edge: data[i] written by any wr_en port with wr_idx==i; ready[i] set by such a write, cleared by any alloc_en with alloc_idx==i.
REQ-022 SHALL, for same-cycle write and alloc to one index, store the write data and leave ready=0 (alloc wins).
REQ-023 SHALL, when several write ports hit one nonzero index, take the highest-numbered port's data and assert wr_conflict=1 on the next cycle; otherwise wr_conflict=0.
REQ-024 SHALL give reads 1-cycle latency: with rd_en[p]=1 at edge t, rd_data[p]/rd_ready[p] after t equal the post-edge-t data/ready of rd_idx[p] (same-cycle writes bypassed, same-cycle alloc/flush applied).
REQ-025 SHALL hold rd_data[p] and rd_ready[p] when rd_en[p]=0.
REQ-026 SHALL, on flush=1, set every ready bit to 1 at that edge, ignore all same-cycle alloc_en, still perform same-cycle writes, and report rd_ready=1 for same-cycle reads.
REQ-027 SHALL have busy_count equal the number of ready bits that are 0 after each edge (range 0..NUM_PREGS-1); 0 after flush.
REQ-028 SHALL treat duplicate alloc indices in one cycle as a single clear (no double count).
REQ-029 SHALL support all NUM_RD reads, NUM_WR writes and NUM_ALLOC allocs in the same cycle with no stall or backpressure.

Reset
REQ-030 SHALL, while rst=1 at an edge, clear all data to 0, set all ready bits to 1, drive rd_data=0, rd_ready=0, wr_conflict=0, busy_count=0; rst overrides flush, writes and allocs.
REQ-031 SHALL, with rst asserted mid-operation, discard that cycle's writes/allocs and resume normally on the first edge with rst=0.

Verification
REQ-032 SHALL cover: reset, then read idx 5 -> rd_data=0, rd_ready=1, busy_count=0.
REQ-033 SHALL cover: alloc 7; next cycle read 7 -> rd_ready=0, busy_count=1; then write 7=0xDEADBEEF with read 7 same cycle -> rd_data=0xDEADBEEF, rd_ready=1, busy_count=0.
REQ-034 SHALL cover: ports 0 and 2 write idx 9 with 0x11/0x22 -> stored 0x22, wr_conflict=1 for one cycle.
REQ-035 SHALL cover: alloc 3,4,5, then flush with alloc 6 same cycle -> busy_count=0, read 6 rd_ready=1.
REQ-036 SHALL cover: write idx 0 = 0xFFFF and alloc 0 -> read 0 gives 0, ready 1, busy_count unchanged.
REQ-037 SHALL cover: alloc 10 and write 10=0x5A same cycle -> read 10 gives 0x5A, rd_ready=0, busy_count=1.
